vectored_interrupt_controller: RTL
==================================

// Module: vectored_interrupt_controller
// PURPOSE
//  Wishbone-slave interrupt controller, NUM_SRC sources, two targets: IRQ and FIRQ.
//  Per source: 2-flop input synchroniser, selectable level/edge mode,
//  edge-pending latch with write-1-to-clear, software-set bits.
//  Fixed-priority vector registers report the highest-priority pending source per target.
//  Sits between peripheral interrupt lines and the CPU irq/firq inputs.
// PARAMETERS
//  NUM_SRC   32  number of sources, 1..32; unused upper register bits read 0, writes ignored
//  ID_W      5   width of vector ID field; must satisfy 2**ID_W >= NUM_SRC
// PORTS
//  i_clk          in   1        system clock
//  i_rst          in   1        synchronous reset, active-high
//  slave          wb_if.slave   32-bit Wishbone slave (ADR, SEL, WE, DAT_W, DAT_R, CYC, STB, ACK, ERR)
//  i_interrupts   in   NUM_SRC  asynchronous interrupt sources, active-high
//  o_irq          out  1        IRQ request, registered
//  o_firq         out  1        FIRQ request, registered
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high.
//  - All enables, mode, soft, pending, sync flops, vectors, o_irq, o_firq and DAT_R are cleared to 0.
//  - Reset mid-transaction drops any outstanding read ack.
//  Wishbone:
//  - ERR is tied to 0.
//  - Write: ACK = STB&WE, combinational, same cycle. Not accepted while a read ack is pending.
//  - Read: data registered on the STB&!WE&!ACK cycle; ACK asserted the following cycle.
//  - SEL is ignored; all accesses are 32-bit.
//  Register map, word index ADR[11:2]:
//  - 0 IRQ_ENSET (OR-set; reads enable), 1 IRQ_ENCLR (AND-NOT clear)
//  - 2 RAWSTAT (RO: sync level | soft)
//  - 3 IRQ_STATUS (RO), 4 FIRQ_ENSET, 5 FIRQ_ENCLR, 6 FIRQ_STATUS (RO)
//  - 7 MODE (RW; bit = 1 selects edge mode)
//  - 8 PENDING (read: pending latch; write: 1 clears bit)
//  - 9 SOFTSET, 10 SOFTCLR (both read the soft register)
//  - 11 IRQ_VECTOR, 12 FIRQ_VECTOR (RO: [31] valid, [ID_W-1:0] id)
//  - Unmapped reads return 0; unmapped writes are ignored.
//  Source evaluation:
//  - sync2 = 2-flop synchronised input.
//  - Level mode: active = sync2 | soft.
//  - Edge mode: pend[i] is set on sync2 & ~sync2_d; active = pend | soft.
//  - STATUS = active & enable, registered.
//  - o_irq <= |irq_status; o_firq <= |firq_status.
//  Latency from the i_clk edge that samples an input rise:
//  - Level mode: o_irq high on the 3rd edge.
//  - Edge mode: pend set on the 3rd edge, o_irq high on the 4th.
//  Edge-case rules:
//  - Edge mode: pend stays set after the input falls; only a PENDING write of 1 clears it.
//  - Same cycle, same bit: edge detect and PENDING clear -> set wins.
//  - Writing a MODE bit to 0 clears that bit's pend.
//  - Writes to enable, soft or mode take effect on status and outputs 2 cycles later.
//  Priority and vectors:
//  - Lowest index = highest priority.
//  - Vector = index of the lowest set bit of STATUS, registered alongside o_irq/o_firq.
//  - valid = 0 and id = 0 when STATUS = 0.
//  - A source enabled for both IRQ and FIRQ drives both outputs.
// STRUCTURE
//  - ic_pkg: register word-index localparams, VALID_BIT = 31, typedef ic_vec_t (valid + id).
//  - Sub-module ic_prio_enc #(N, ID_W): combinational lowest-set-bit encoder -> {valid, id}.
//    Instanced twice (IRQ, FIRQ); all other logic stays in this module.
// TESTING
//  T1: ENSET = 0x10; pulse i_interrupts[4] high (level mode)
//      -> o_irq high 3 clocks after sampling; IRQ_VECTOR = 0x8000_0004.
//  T2: MODE = 0x1, IRQ_EN = 0x1; 1-cycle pulse on bit 0
//      -> PENDING = 0x1, o_irq stays high until PENDING write 0x1; o_irq low 2 clocks later.
//  T3: IRQ_EN = 0xFFFF_FFFF; raise bits 9 and 3 together
//      -> IRQ_VECTOR id = 3; clear bit 3 -> id = 9.
//  T4: SOFTSET 0x8000_0000 with FIRQ_EN[31] = 1
//      -> o_firq = 1, o_irq = 0; SOFTCLR 0x8000_0000 -> o_firq = 0.
//  T5: edge detect on bit 2 in the same cycle as a PENDING write of 0x4
//      -> PENDING reads 0x4.
//  T6: read ACK exactly 1 cycle after STB; back-to-back write held until the read ACK;
//      i_rst mid-read -> ACK low and all outputs 0 the next cycle.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared register map, vector payload type and helpers for the vectored interrupt controller.
package ic_pkg;

  localparam int unsigned WB_DW     = 32;
  localparam int unsigned WORD_W    = 10;
  localparam int unsigned VALID_BIT = 31;
  // Widest vector id ever needed: 32 sources.
  localparam int unsigned VEC_ID_W  = 5;

  localparam logic [WORD_W-1:0] REG_IRQ_ENSET   = WORD_W'(0);
  localparam logic [WORD_W-1:0] REG_IRQ_ENCLR   = WORD_W'(1);
  localparam logic [WORD_W-1:0] REG_RAWSTAT     = WORD_W'(2);
  localparam logic [WORD_W-1:0] REG_IRQ_STATUS  = WORD_W'(3);
  localparam logic [WORD_W-1:0] REG_FIRQ_ENSET  = WORD_W'(4);
  localparam logic [WORD_W-1:0] REG_FIRQ_ENCLR  = WORD_W'(5);
  localparam logic [WORD_W-1:0] REG_FIRQ_STATUS = WORD_W'(6);
  localparam logic [WORD_W-1:0] REG_MODE        = WORD_W'(7);
  localparam logic [WORD_W-1:0] REG_PENDING     = WORD_W'(8);
  localparam logic [WORD_W-1:0] REG_SOFTSET     = WORD_W'(9);
  localparam logic [WORD_W-1:0] REG_SOFTCLR     = WORD_W'(10);
  localparam logic [WORD_W-1:0] REG_IRQ_VECTOR  = WORD_W'(11);
  localparam logic [WORD_W-1:0] REG_FIRQ_VECTOR = WORD_W'(12);

  typedef struct packed {
    logic                valid;
    logic [VEC_ID_W-1:0] id;
  } ic_vec_t;

  // Place a vector into its 32-bit register image: valid at the top, id at the bottom.
  function automatic logic [WB_DW-1:0] vec_word(input ic_vec_t v);
    logic [WB_DW-1:0] w;
    w                = '0;
    w[VALID_BIT]     = v.valid;
    w[VEC_ID_W-1:0]  = v.id;
    return w;
  endfunction

endpackage

// File: rtl/wb_if.sv
// 32-bit Wishbone bus bundle with a slave view.
interface wb_if;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport slave (
    input  adr, sel, we, dat_w, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/ic_prio_enc.sv
// Combinational fixed-priority encoder: reports the lowest set request bit.
module ic_prio_enc #(
  parameter int unsigned N    = 32,
  parameter int unsigned ID_W = 5
) (
  input  logic [N-1:0]    req_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  // Scan from the top so the lowest index is the last (winning) assignment.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/vectored_interrupt_controller.sv
// Wishbone interrupt controller: synchronised sources, level/edge modes, soft bits,
// and fixed-priority vectors for the IRQ and FIRQ targets.
module vectored_interrupt_controller
  import ic_pkg::*;
#(
  parameter int unsigned NUM_SRC = 32,
  parameter int unsigned ID_W    = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  wb_if.slave                slave,
  input  logic [NUM_SRC-1:0] i_interrupts,
  output logic               o_irq,
  output logic               o_firq
);

  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] irq_en_q, irq_en_d, firq_en_q, firq_en_d;
  logic [NUM_SRC-1:0] mode_q, mode_d, soft_q, soft_d, pend_q, pend_d;
  logic [NUM_SRC-1:0] irq_status_q, firq_status_q;
  logic               irq_q, firq_q;
  ic_vec_t            irq_vec_q, firq_vec_q;
  logic               rd_ack_q;
  logic [WB_DW-1:0]   dat_r_q;

  logic [WORD_W-1:0]  word;
  logic [NUM_SRC-1:0] wdat, pend_clr, rise, active, irq_act, firq_act;
  logic               wr_en, rd_start;
  logic [WB_DW-1:0]   rd_data;
  logic               irq_vld, firq_vld;
  logic [ID_W-1:0]    irq_id, firq_id;
  logic               unused_wb;

  assign word      = slave.adr[11:2];
  assign wdat      = slave.dat_w[NUM_SRC-1:0];
  assign wr_en     = slave.cyc & slave.stb & slave.we & ~rd_ack_q;
  assign rd_start  = slave.cyc & slave.stb & ~slave.we & ~rd_ack_q;
  assign slave.ack = rd_ack_q | wr_en;
  assign slave.err = 1'b0;
  assign slave.dat_r = dat_r_q;
  assign unused_wb = ^{slave.adr[31:12], slave.adr[1:0], slave.sel};

  // Register writes and pending-latch update; an edge in the same cycle beats a clear.
  always_comb begin
    irq_en_d  = irq_en_q;
    firq_en_d = firq_en_q;
    mode_d    = mode_q;
    soft_d    = soft_q;
    pend_clr  = '0;
    if (wr_en) begin
      case (word)
        REG_IRQ_ENSET:  irq_en_d  = irq_en_q | wdat;
        REG_IRQ_ENCLR:  irq_en_d  = irq_en_q & ~wdat;
        REG_FIRQ_ENSET: firq_en_d = firq_en_q | wdat;
        REG_FIRQ_ENCLR: firq_en_d = firq_en_q & ~wdat;
        REG_MODE:       mode_d    = wdat;
        REG_PENDING:    pend_clr  = wdat;
        REG_SOFTSET:    soft_d    = soft_q | wdat;
        REG_SOFTCLR:    soft_d    = soft_q & ~wdat;
        default:        ;
      endcase
    end
    rise     = sync2_q & ~sync3_q;
    pend_d   = ((pend_q & ~pend_clr) | (rise & mode_q)) & mode_d;
    active   = (mode_q & pend_q) | (~mode_q & sync2_q) | soft_q;
    irq_act  = active & irq_en_q;
    firq_act = active & firq_en_q;
  end

  ic_prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_irq_enc (
    .req_i   (irq_act),
    .valid_o (irq_vld),
    .id_o    (irq_id)
  );

  ic_prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_firq_enc (
    .req_i   (firq_act),
    .valid_o (firq_vld),
    .id_o    (firq_id)
  );

  // Read data mux; narrow registers are zero-extended to the bus width.
  always_comb begin
    rd_data = '0;
    case (word)
      REG_IRQ_ENSET, REG_IRQ_ENCLR:   rd_data = WB_DW'(irq_en_q);
      REG_RAWSTAT:                    rd_data = WB_DW'(sync2_q | soft_q);
      REG_IRQ_STATUS:                 rd_data = WB_DW'(irq_status_q);
      REG_FIRQ_ENSET, REG_FIRQ_ENCLR: rd_data = WB_DW'(firq_en_q);
      REG_FIRQ_STATUS:                rd_data = WB_DW'(firq_status_q);
      REG_MODE:                       rd_data = WB_DW'(mode_q);
      REG_PENDING:                    rd_data = WB_DW'(pend_q);
      REG_SOFTSET, REG_SOFTCLR:       rd_data = WB_DW'(soft_q);
      REG_IRQ_VECTOR:                 rd_data = vec_word(irq_vec_q);
      REG_FIRQ_VECTOR:                rd_data = vec_word(firq_vec_q);
      default:                        rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      sync3_q       <= '0;
      irq_en_q      <= '0;
      firq_en_q     <= '0;
      mode_q        <= '0;
      soft_q        <= '0;
      pend_q        <= '0;
      irq_status_q  <= '0;
      firq_status_q <= '0;
      irq_q         <= 1'b0;
      firq_q        <= 1'b0;
      irq_vec_q     <= '0;
      firq_vec_q    <= '0;
      rd_ack_q      <= 1'b0;
      dat_r_q       <= '0;
    end else begin
      sync1_q       <= i_interrupts;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      irq_en_q      <= irq_en_d;
      firq_en_q     <= firq_en_d;
      mode_q        <= mode_d;
      soft_q        <= soft_d;
      pend_q        <= pend_d;
      irq_status_q  <= irq_act;
      firq_status_q <= firq_act;
      irq_q         <= |irq_act;
      firq_q        <= |firq_act;
      irq_vec_q     <= '{valid: irq_vld, id: VEC_ID_W'(irq_id)};
      firq_vec_q    <= '{valid: firq_vld, id: VEC_ID_W'(firq_id)};
      rd_ack_q      <= rd_start;
      if (rd_start) begin
        dat_r_q <= rd_data;
      end
    end
  end

  assign o_irq  = irq_q;
  assign o_firq = firq_q;

endmodule
